// File: rtl/downscale_pkg.sv
// Shared definitions for the 2x2 box-average downscaler.
// Holds the state encoding, the default widths and the accumulator width.
package downscale_pkg;

    localparam int unsigned N_LOG2_DEF = 7;
    localparam int unsigned DATA_W_DEF = 8;
    // Four DATA_W pixels sum without overflow in DATA_W+2 bits.
    localparam int unsigned SUM_W      = DATA_W_DEF + 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD0  = 3'd1;
    localparam logic [2:0] ST_RD1  = 3'd2;
    localparam logic [2:0] ST_RD2  = 3'd3;
    localparam logic [2:0] ST_RD3  = 3'd4;
    localparam logic [2:0] ST_WR   = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD0  = ST_RD0,
        RD1  = ST_RD1,
        RD2  = ST_RD2,
        RD3  = ST_RD3,
        WR   = ST_WR,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/box_accum.sv
// Running sum of the four pixels of one 2x2 block and its mean.
// Build option: define DOWNSCALE_ROUND_EN for round-half-up, otherwise the mean truncates.
module box_accum
    import downscale_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] pixel,
    output logic [DATA_W-1:0] mean
);

    localparam int unsigned ACC_W = DATA_W + 2;

    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_d;
    logic [ACC_W-1:0] sum4;
    logic [ACC_W-1:0] biased;

    // Next sum: clear at the start of a block, otherwise add the returning pixel.
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + ACC_W'(pixel);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // The fourth pixel arrives in the write cycle, so it is folded in combinationally.
    always_comb begin
        sum4 = sum_q + ACC_W'(pixel);
`ifdef DOWNSCALE_ROUND_EN
        biased = sum4 + ACC_W'(2);
`else
        biased = sum4;
`endif
        mean = DATA_W'(biased >> 2);
    end

endmodule

// File: rtl/downscale_controller.sv
// Readback controller: reads the 2^(N_LOG2+1) square source image and writes one
// box-averaged pixel per 2x2 block to the result memory, 5 cycles per output pixel.
// Build option: DOWNSCALE_ROUND_EN selects rounding in box_accum.
module downscale_controller
    import downscale_pkg::*;
#(
    parameter int unsigned N_LOG2 = N_LOG2_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [2*N_LOG2+1:0]   RAM_A,
    output logic                  RAM_OE,
    input  logic [DATA_W-1:0]     RAM_Q,
    output logic [2*N_LOG2-1:0]   RES_A,
    output logic                  RES_WE,
    output logic [DATA_W-1:0]     RES_D,
    output logic                  busy,
    output logic                  done
);

    localparam logic [N_LOG2-1:0] CNT_ONE = {{(N_LOG2-1){1'b0}}, 1'b1};

    state_t            state_q;
    state_t            state_d;
    logic [N_LOG2-1:0] oy_q;
    logic [N_LOG2-1:0] oy_d;
    logic [N_LOG2-1:0] ox_q;
    logic [N_LOG2-1:0] ox_d;
    logic              acc_clear;
    logic              acc_add;
    logic [DATA_W-1:0] acc_mean;

    box_accum #(
        .DATA_W(DATA_W)
    ) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clear(acc_clear),
        .add  (acc_add),
        .pixel(RAM_Q),
        .mean (acc_mean)
    );

    // Next state, raster counters and all outputs, decoded from the current state.
    always_comb begin
        state_d   = state_q;
        oy_d      = oy_q;
        ox_d      = ox_q;
        RAM_A     = '0;
        RAM_OE    = 1'b0;
        RES_A     = '0;
        RES_WE    = 1'b0;
        RES_D     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD0;
                end
            end
            RD0: begin
                RAM_A     = {oy_q, 1'b0, ox_q, 1'b0};
                RAM_OE    = 1'b1;
                busy      = 1'b1;
                acc_clear = 1'b1;
                state_d   = RD1;
            end
            RD1: begin
                RAM_A   = {oy_q, 1'b0, ox_q, 1'b1};
                RAM_OE  = 1'b1;
                busy    = 1'b1;
                acc_add = 1'b1;
                state_d = RD2;
            end
            RD2: begin
                RAM_A   = {oy_q, 1'b1, ox_q, 1'b0};
                RAM_OE  = 1'b1;
                busy    = 1'b1;
                acc_add = 1'b1;
                state_d = RD3;
            end
            RD3: begin
                RAM_A   = {oy_q, 1'b1, ox_q, 1'b1};
                RAM_OE  = 1'b1;
                busy    = 1'b1;
                acc_add = 1'b1;
                state_d = WR;
            end
            WR: begin
                RES_WE  = 1'b1;
                RES_A   = {oy_q, ox_q};
                RES_D   = acc_mean;
                busy    = 1'b1;
                acc_add = 1'b1;
                // Counters wrap to zero on the last pixel, leaving them cleared for DONE.
                ox_d    = ox_q + CNT_ONE;
                state_d = RD0;
                if (&ox_q) begin
                    oy_d = oy_q + CNT_ONE;
                    if (&oy_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = RD0;
                end
            end
            default: begin
                state_d = IDLE;
                oy_d    = '0;
                ox_d    = '0;
            end
        endcase
    end

    // State and raster counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            oy_q    <= '0;
            ox_q    <= '0;
        end else begin
            state_q <= state_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
        end
    end

endmodule

// File: tb/tb_downscale_controller.sv
// Self-checking bench for downscale_controller, run at N_LOG2=4 (32x32 source, 16x16 result)
// so several complete frames fit in a short run.
module tb_downscale_controller;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int AW     = 2 * N + 2;
    localparam int RW     = 2 * N;
    localparam int OSIDE  = 1 << N;
    localparam int SIDE   = 1 << (N + 1);
    localparam int P      = OSIDE * OSIDE;
    localparam int SRC    = SIDE * SIDE;
    localparam int FRAME  = 5 * P;
`ifdef DOWNSCALE_ROUND_EN
    localparam int RND    = 2;
    localparam int EXP_B0 = 11;
`else
    localparam int RND    = 0;
    localparam int EXP_B0 = 10;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] RAM_A;
    logic          RAM_OE;
    logic [DW-1:0] ram_q = '0;
    logic [RW-1:0] RES_A;
    logic          RES_WE;
    logic [DW-1:0] RES_D;
    logic          busy;
    logic          done;

    downscale_controller #(
        .N_LOG2(N),
        .DATA_W(DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .RAM_A (RAM_A),
        .RAM_OE(RAM_OE),
        .RAM_Q (ram_q),
        .RES_A (RES_A),
        .RES_WE(RES_WE),
        .RES_D (RES_D),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM: one-cycle read latency.
    logic [DW-1:0] src [SRC];
    always @(posedge clk) begin
        if (RAM_OE) ram_q <= src[RAM_A];
    end

    // Frame-level reference: busy for 5P cycles after an accepted start, then done.
    logic m_busy;
    logic m_done;
    int   m_t;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
        end else if (m_busy) begin
            if (m_t == FRAME - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_t    <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_t    <= 0;
        end
    end

    int            checks = 0;
    int            errors = 0;
    int            wr_count;
    logic [DW-1:0] got [P];
    logic [RW-1:0] last_wa;
    logic [RW-1:0] ones = '1;

    function automatic logic [AW-1:0] src_addr(input int k, input int sub);
        int row = 2 * (k / OSIDE) + sub / 2;
        int col = 2 * (k % OSIDE) + sub % 2;
        return AW'(row * SIDE + col);
    endfunction

    function automatic logic [DW-1:0] box(input int k);
        int s = 0;
        for (int sub = 0; sub < 4; sub++) s += int'(src[src_addr(k, sub)]);
        return DW'((s + RND) / 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the reference.
    task automatic compare();
        bit exp_we = m_busy && (m_t % 5 == 4);
        bit exp_oe = m_busy && (m_t % 5 != 4);
        int k      = m_t / 5;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("RES_WE", 32'(RES_WE), 32'(exp_we));
        chk("RAM_OE", 32'(RAM_OE), 32'(exp_oe));
        if (exp_oe) chk("RAM_A", 32'(RAM_A), 32'(src_addr(k, m_t % 5)));
        if (exp_we) begin
            chk("RES_A", 32'(RES_A), 32'(k));
            chk("RES_D", 32'(RES_D), 32'(box(k)));
        end
        if (RES_WE === 1'b1) begin
            wr_count++;
            got[int'(RES_A)] = RES_D;
            last_wa = RES_A;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_got();
        wr_count = 0;
        for (int i = 0; i < P; i++) got[i] = '0;
    endtask

    // Start a frame and wait for done; optional start pulses mid-frame or start held throughout.
    task automatic run_frame(input bit pulse, input bit hold, output int n);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            start = hold || (pulse && n >= 100 && n < 104);
        end while (done !== 1'b1 && n < FRAME + 20);
        chk("frame_len", 32'(n), 32'(FRAME + 1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_RAM_A"}, 32'(RAM_A), 32'(0));
        chk({tag, "_RAM_OE"}, 32'(RAM_OE), 32'(0));
        chk({tag, "_RES_A"}, 32'(RES_A), 32'(0));
        chk({tag, "_RES_WE"}, 32'(RES_WE), 32'(0));
        chk({tag, "_RES_D"}, 32'(RES_D), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        int n;
        int bad;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < SRC; i++) src[i] = DW'($urandom);
        clear_got();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();

        // Random image with two hand-computed blocks planted at the corners.
        src[0] = 8'd10;
        src[1] = 8'd11;
        src[SIDE] = 8'd11;
        src[SIDE + 1] = 8'd11;
        src[(SIDE - 2) * SIDE + SIDE - 2] = 8'd255;
        src[(SIDE - 2) * SIDE + SIDE - 1] = 8'd255;
        src[(SIDE - 1) * SIDE + SIDE - 2] = 8'd255;
        src[(SIDE - 1) * SIDE + SIDE - 1] = 8'd255;
        clear_got();
        run_frame(1'b0, 1'b0, n);
        chk("block0", 32'(got[0]), 32'(EXP_B0));
        chk("block_last", 32'(got[P - 1]), 32'(255));
        chk("last_addr", 32'(last_wa), 32'(ones));
        chk("wr_count_rand", 32'(wr_count), 32'(P));
        chk("end_done", 32'(done), 32'(1));
        chk("end_busy", 32'(busy), 32'(0));
        repeat (5) tick();

        // Upscaled ramp, with start pulsed while busy.
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) src[r * SIDE + c] = DW'(c / 2);
        clear_got();
        run_frame(1'b1, 1'b0, n);
        bad = 0;
        for (int i = 0; i < P; i++) if (got[i] !== DW'(i % OSIDE)) bad++;
        chk("ramp_recover", 32'(bad), 32'(0));
        chk("wr_count_ramp", 32'(wr_count), 32'(P));

        // Flat 0xC8 image with start held high into DONE: immediate restart.
        for (int i = 0; i < SRC; i++) src[i] = 8'hC8;
        clear_got();
        run_frame(1'b0, 1'b1, n);
        chk("wr_count_c8", 32'(wr_count), 32'(P));
        bad = 0;
        for (int i = 0; i < P; i++) if (got[i] !== 8'hC8) bad++;
        chk("c8_all", 32'(bad), 32'(0));
        tick();
        chk("restart_done", 32'(done), 32'(0));
        chk("restart_busy", 32'(busy), 32'(1));
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < FRAME + 20) begin
            tick();
            n++;
        end
        chk("frame2_len", 32'(n), 32'(FRAME + 1));

        // Reset mid-frame: outputs clear at once and stay quiet until a new start.
        for (int i = 0; i < SRC; i++) src[i] = DW'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (999) tick();
        chk("pre_rst_busy", 32'(busy), 32'(1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        wr_count = 0;
        repeat (2) tick();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) tick();
        chk("no_we_after_rst", 32'(wr_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
